btu_detranspose: RTL and testbench

- Receive-side inverse of the bit transpose unit.
- Accepts a header carrying element width n, then a serial stream of bit-plane rows (one 32-bit row per beat). It rebuilds the 32 original data words and emits them one word per beat.
- Sits between the row-stream interconnect and downstream word consumers; the row-count rule matches the transposer exactly.

---
 rtl/btu_pkg.sv | 25 ++
 rtl/btu_detranspose.sv | 104 ++++++++++
 tb/tb_btu_detranspose.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/btu_pkg.sv
// Shared constants, FSM state type and row-count rule for the bit transpose unit pair.
// Both the transposer and btu_detranspose call btu_num_rows() so the two ends agree.
package btu_pkg;

    localparam int NUM_WORDS  = 32;
    localparam int DATA_WIDTH = 32;
    localparam int N_WIDTH    = 4;
    localparam int ROW_CNT_W  = 6;   // holds 0..32 planes
    localparam int WORD_IDX_W = 5;

    typedef enum logic [1:0] {
        DT_IDLE    = 2'd0,
        DT_COLLECT = 2'd1,
        DT_EMIT    = 2'd2
    } btu_dt_state_t;

    // Wide elements (n>=9) travel as 2n planes, narrow ones as 4n planes.
    function automatic logic [ROW_CNT_W-1:0] btu_num_rows(input logic [N_WIDTH-1:0] n);
        logic [ROW_CNT_W-1:0] r;
        if (n >= 4'd9) r = {1'b0, n, 1'b0};
        else           r = {n, 2'b00};
        return r;
    endfunction

endpackage

// File: rtl/btu_detranspose.sv
// Receive-side inverse of the bit transpose unit: collects R bit-plane rows into a
// 32x32 plane buffer, then emits the 32 reconstructed words one per handshake.
module btu_detranspose
    import btu_pkg::*;
#(
    parameter int NUM_WORDS  = btu_pkg::NUM_WORDS,
    parameter int DATA_WIDTH = btu_pkg::DATA_WIDTH,
    parameter int N_WIDTH    = btu_pkg::N_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hdr_valid,
    output logic                  hdr_ready,
    input  logic [N_WIDTH-1:0]    hdr_n,
    input  logic                  row_valid,
    output logic                  row_ready,
    input  logic [NUM_WORDS-1:0]  row_data,
    input  logic                  row_last,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic [DATA_WIDTH-1:0] word_data,
    output logic [4:0]            word_idx,
    output logic                  word_last,
    output logic                  row_err
);

    btu_dt_state_t         state_q;
    logic [ROW_CNT_W-1:0]  rows_q;
    logic [ROW_CNT_W-1:0]  row_cnt_q;
    logic [WORD_IDX_W-1:0] word_cnt_q;
    logic                  row_err_q;
    logic [NUM_WORDS-1:0]  plane_q [DATA_WIDTH];

    logic                  hdr_hs, row_hs, word_hs;
    logic                  last_row;
    logic [ROW_CNT_W-1:0]  rows_d;

    assign hdr_ready  = (state_q == DT_IDLE);
    assign row_ready  = (state_q == DT_COLLECT);
    assign word_valid = (state_q == DT_EMIT);

    assign hdr_hs  = hdr_valid  && hdr_ready;
    assign row_hs  = row_valid  && row_ready;
    assign word_hs = word_valid && word_ready;

    assign rows_d   = btu_num_rows(hdr_n);
    assign last_row = (row_cnt_q == (rows_q - 6'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= DT_IDLE;
            rows_q     <= '0;
            row_cnt_q  <= '0;
            word_cnt_q <= '0;
            row_err_q  <= 1'b0;
        end else begin
            row_err_q <= 1'b0;
            unique case (state_q)
                DT_IDLE: begin
                    if (hdr_hs) begin
                        rows_q     <= rows_d;
                        row_cnt_q  <= '0;
                        word_cnt_q <= '0;
                        state_q    <= (rows_d == '0) ? DT_EMIT : DT_COLLECT;
                    end
                end
                DT_COLLECT: begin
                    if (row_hs) begin
                        row_cnt_q <= row_cnt_q + 6'd1;
                        // row_last is advisory only: it flags errors but never ends collection
                        row_err_q <= (row_last != last_row);
                        if (last_row) state_q <= DT_EMIT;
                    end
                end
                DT_EMIT: begin
                    if (word_hs) begin
                        word_cnt_q <= word_cnt_q + 5'd1;
                        if (word_cnt_q == 5'd31) state_q <= DT_IDLE;
                    end
                end
                default: state_q <= DT_IDLE;
            endcase
        end
    end

    // Plane buffer has no reset; the clear on header acceptance zeroes planes >= R.
    always_ff @(posedge clk) begin
        if (hdr_hs) begin
            for (int r = 0; r < DATA_WIDTH; r++) plane_q[r] <= '0;
        end else if (row_hs) begin
            plane_q[row_cnt_q[4:0]] <= row_data;
        end
    end

    always_comb begin
        word_data = '0;
        for (int r = 0; r < DATA_WIDTH; r++) word_data[r] = plane_q[r][word_cnt_q];
    end

    assign word_idx  = word_cnt_q;
    assign word_last = (word_cnt_q == 5'd31);
    assign row_err   = row_err_q;

endmodule

// File: tb/tb_btu_detranspose.sv
// Directed bench for btu_detranspose: row collection, word emission, row_last checking,
// stalls and asynchronous reset mid-block.
module tb_btu_detranspose;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hdr_valid, hdr_ready;
    logic [3:0]  hdr_n;
    logic        row_valid, row_ready, row_last;
    logic [31:0] row_data;
    logic        word_valid, word_ready, word_last, row_err;
    logic [31:0] word_data;
    logic [4:0]  word_idx;

    int checks = 0;
    int errors = 0;

    logic [31:0] rows_a [32];
    logic [31:0] exp_w  [32];
    logic        err_s;

    always #5 clk = ~clk;

    btu_detranspose dut (
        .clk(clk), .rst_n(rst_n),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_n(hdr_n),
        .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data), .row_last(row_last),
        .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
        .word_idx(word_idx), .word_last(word_last), .row_err(row_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Expected word c: bit r taken from column c of row r, for the first R rows only.
    task automatic build_exp(input int nrows);
        for (int c = 0; c < 32; c++) begin
            exp_w[c] = 32'h0;
            for (int r = 0; r < nrows; r++) exp_w[c][r] = rows_a[r][c];
        end
    endtask

    // All tasks start and end at a negedge.
    task automatic send_hdr(input logic [3:0] n);
        int g = 0;
        hdr_valid = 1'b1;
        hdr_n     = n;
        while (!hdr_ready && g < 100) begin @(negedge clk); g++; end
        chk("hdr_timeout", {31'b0, hdr_ready}, 32'h1);
        @(negedge clk);
        hdr_valid = 1'b0;
    endtask

    task automatic send_row(input logic [31:0] d, input logic last, output logic err);
        int g = 0;
        row_valid = 1'b1;
        row_data  = d;
        row_last  = last;
        while (!row_ready && g < 100) begin @(negedge clk); g++; end
        chk("row_timeout", {31'b0, row_ready}, 32'h1);
        @(negedge clk);
        row_valid = 1'b0;
        row_last  = 1'b0;
        err       = row_err;
    endtask

    task automatic recv_block(input bit stall);
        int  idx = 0;
        int  g   = 0;
        bit  rdy;
        while (idx < 32 && g < 2000) begin
            if (!word_valid) begin
                chk("word_valid", {31'b0, word_valid}, 32'h1);
                break;
            end
            chk("row_ready_in_emit", {31'b0, row_ready}, 32'h0);
            chk("word_idx",  {27'b0, word_idx}, idx);
            chk("word_data", word_data, exp_w[idx]);
            chk("word_last", {31'b0, word_last}, (idx == 31) ? 32'h1 : 32'h0);
            rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            word_ready = rdy;
            @(negedge clk);
            if (rdy) idx++;
            g++;
        end
        word_ready = 1'b0;
        chk("words_done", idx, 32);
        chk("idle_after_block", {30'b0, hdr_ready, word_valid}, 32'h2);
    endtask

    initial begin
        rst_n = 1'b0; hdr_valid = 0; hdr_n = 0; row_valid = 0; row_data = 0;
        row_last = 0; word_ready = 0;
        @(negedge clk);
        chk("rst_hdr_ready", {31'b0, hdr_ready}, 32'h1);
        chk("rst_outputs", {29'b0, row_ready, word_valid, row_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // n=8 -> R=32, diagonal planes give one-hot words
        send_hdr(4'd8);
        chk("n8_row_ready", {31'b0, row_ready}, 32'h1);
        for (int r = 0; r < 32; r++) begin
            send_row(32'h1 << r, r == 31, err_s);
            chk("n8_row_err", {31'b0, err_s}, 32'h0);
        end
        for (int c = 0; c < 32; c++) exp_w[c] = 32'h1 << c;
        recv_block(1'b0);

        // n=9 -> R=18, all-ones rows
        send_hdr(4'd9);
        for (int r = 0; r < 18; r++) begin
            if (r == 17) chk("n9_not_yet_valid", {30'b0, row_ready, word_valid}, 32'h2);
            send_row(32'hFFFF_FFFF, r == 17, err_s);
        end
        chk("n9_valid_after_18", {31'b0, word_valid}, 32'h1);
        for (int c = 0; c < 32; c++) exp_w[c] = 32'h0003_FFFF;
        recv_block(1'b0);

        // n=0 -> R=0, straight to EMIT with zero words
        send_hdr(4'd0);
        chk("n0_first_valid", {30'b0, row_ready, word_valid}, 32'h1);
        for (int c = 0; c < 32; c++) exp_w[c] = 32'h0;
        recv_block(1'b0);

        // n=2 -> R=8, row_last misplaced on row 3 and missing on row 7
        send_hdr(4'd2);
        for (int r = 0; r < 8; r++) begin
            rows_a[r] = 32'h1357_9BDF ^ (32'h0101_0101 << r);
            send_row(rows_a[r], r == 3, err_s);
            chk($sformatf("n2_row_err_%0d", r), {31'b0, err_s}, (r == 3 || r == 7) ? 32'h1 : 32'h0);
        end
        chk("n2_emit_after_8", {30'b0, row_ready, word_valid}, 32'h1);
        build_exp(8);
        recv_block(1'b0);

        // n=15 -> R=30 with random downstream stalls
        send_hdr(4'd15);
        for (int r = 0; r < 30; r++) begin
            rows_a[r] = $urandom;
            send_row(rows_a[r], r == 29, err_s);
        end
        build_exp(30);
        recv_block(1'b1);
        for (int c = 0; c < 32; c++) chk("n15_top_bits", {30'b0, exp_w[c][31:30]}, 32'h0);

        // n=4 -> R=16, reset after 5 rows, then n=1 block must carry no residue
        send_hdr(4'd4);
        for (int r = 0; r < 5; r++) send_row(32'hFFFF_FFFF, 1'b0, err_s);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_collect", {29'b0, hdr_ready, row_ready, word_valid}, 32'h4);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_hdr(4'd1);
        rows_a[0] = 32'h0000_FFFF; rows_a[1] = 32'hFFFF_0000;
        rows_a[2] = 32'h00FF_00FF; rows_a[3] = 32'h0F0F_0F0F;
        for (int r = 0; r < 4; r++) send_row(rows_a[r], r == 3, err_s);
        exp_w[0]  = 32'h0000_000D;   // col 0: planes 0,2,3 set
        exp_w[31] = 32'h0000_0002;   // col 31: only plane 1 set
        chk("blk2_word0_hand",  {28'b0, rows_a[0][0], rows_a[1][0], rows_a[2][0], rows_a[3][0]}, 32'hB);
        build_exp(4);
        chk("blk2_word0_model", exp_w[0], 32'h0000_000D);
        chk("blk2_word31_model", exp_w[31], 32'h0000_0002);
        recv_block(1'b0);

        // reset mid-EMIT drops word_valid at once
        send_hdr(4'd0);
        word_ready = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_emit", {29'b0, hdr_ready, row_ready, word_valid}, 32'h4);
        word_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
